// File: rtl/uart_echo_top.sv
// UART 8N1 loopback: receive bytes, latch the last good one on LED_Out,
// and retransmit each good byte with a one-entry pending buffer.
module uart_echo_top #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       RX_Pin_In,
  output logic       TX_Pin_Out,
  output logic [7:0] LED_Out
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [2:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_done_q, rx_done_d;
  logic          rx_fall;

  logic [1:0]    tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_free, launch;
  logic [7:0]    launch_byte;

  logic          pend_q, pend_d;
  logic [7:0]    pend_data_q, pend_data_d;
  logic [7:0]    led_q, led_d;

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  always_ff @(posedge clk) begin
    if (RSTn) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= RX_Pin_In;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q;
    rx_idx_d  = rx_idx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    rx_done_d = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_cnt_d = '0;
          rx_st_d  = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_idx_d = '0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_idx_d = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_data_d = rx_sh_q;
            rx_done_d = 1'b1;
            rx_st_d   = RX_IDLE;
          end else begin
            rx_st_d = RX_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT: begin
        // framing error: hold off until the line idles again
        if (rx_s2_q) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RSTn) begin
      rx_st_q   <= RX_IDLE;
      rx_cnt_q  <= '0;
      rx_idx_q  <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      rx_done_q <= 1'b0;
    end else begin
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_idx_q  <= rx_idx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_done_q <= rx_done_d;
    end
  end

  // a fresh byte wins over an older pending one
  assign tx_free     = (tx_st_q == TX_IDLE) | tx_done_q;
  assign launch      = tx_free & (rx_done_q | pend_q);
  assign launch_byte = rx_done_q ? rx_data_q : pend_data_q;

  always_comb begin
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    led_d       = rx_done_q ? rx_data_q : led_q;
    if (rx_done_q && !tx_free) begin
      pend_d      = 1'b1;
      pend_data_d = rx_data_q;
    end else if (launch) begin
      pend_d = 1'b0;
    end
  end

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_cnt_q;
    tx_idx_d  = tx_idx_q;
    tx_sh_d   = tx_sh_q;
    tx_d      = tx_q;
    tx_done_d = 1'b0;
    unique case (tx_st_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (launch) begin
          tx_sh_d  = launch_byte;
          tx_d     = 1'b0;
          tx_cnt_d = '0;
          tx_st_d  = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_idx_d = '0;
          tx_d     = tx_sh_q[0];
          tx_st_d  = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            tx_st_d = TX_STOP;
          end else begin
            tx_d     = tx_sh_q[1];
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_idx_d = tx_idx_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d  = '0;
          tx_done_d = 1'b1;
          tx_st_d   = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RSTn) begin
      tx_st_q     <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_sh_q     <= '0;
      tx_q        <= 1'b1;
      tx_done_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      led_q       <= '0;
    end else begin
      tx_st_q     <= tx_st_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_sh_q     <= tx_sh_d;
      tx_q        <= tx_d;
      tx_done_q   <= tx_done_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      led_q       <= led_d;
    end
  end

  assign TX_Pin_Out = tx_q;
  assign LED_Out    = led_q;

endmodule

// File: tb/tb_uart_echo_top.sv
// Bench for uart_echo_top: drives serial frames, decodes the echo line
// bit-window by bit-window, and compares against a byte-queue model.
module tb_uart_echo_top;

  localparam int CPB = 16;

  logic       clk;
  logic       RSTn;
  logic       RX_Pin_In;
  logic       TX_Pin_Out;
  logic [7:0] LED_Out;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_led;
  logic [7:0] mon_bytes[$];
  bit         mon_good[$];
  int         mon_aborts = 0;
  int         mon_frames = 0;

  uart_echo_top #(
    .CLK_FREQ(1600000),
    .BAUD    (100000)
  ) dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .RX_Pin_In (RX_Pin_In),
    .TX_Pin_Out(TX_Pin_Out),
    .LED_Out   (LED_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // echo line decoder: every bit window must hold one value for CPB clocks
  initial begin
    logic [9:0] v;
    bit good, abrt;
    forever begin
      @(negedge clk);
      if (!RSTn && TX_Pin_Out === 1'b0) begin
        good = 1;
        abrt = 0;
        v = '0;
        mon_frames++;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (RSTn) abrt = 1;
          if (k % CPB == 0) v[k / CPB] = TX_Pin_Out;
          else if (TX_Pin_Out !== v[k / CPB]) good = 0;
          @(negedge clk);
        end
        if (TX_Pin_Out !== 1'b1) good = 0;
        if (v[0] !== 1'b0 || v[9] !== 1'b1) good = 0;
        if (abrt) mon_aborts++;
        else begin
          mon_bytes.push_back(v[8:1]);
          mon_good.push_back(good);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX_Pin_In = f[i];
      repeat (CPB) @(negedge clk);
    end
    RX_Pin_In = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_bits(b, 1'b1);
    exp_q.push_back(b);
    exp_led = b;
  endtask

  task automatic drain(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      for (int t = 0; t < 15 * CPB && mon_bytes.size() == 0; t++)
        @(negedge clk);
      chk({tag, "_seen"}, 32'(mon_bytes.size() != 0), 32'd1);
      e = exp_q.pop_front();
      if (mon_bytes.size() == 0) return;
      chk({tag, "_byte"}, 32'(mon_bytes.pop_front()), 32'(e));
      chk({tag, "_shape"}, 32'(mon_good.pop_front()), 32'd1);
    end
  endtask

  initial begin
    int nf;
    logic [7:0] b;
    RX_Pin_In = 1'b1;
    RSTn = 1'b1;
    exp_led = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_tx", 32'(TX_Pin_Out), 32'd1);
    chk("rst_led", 32'(LED_Out), 32'h00);
    RSTn = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    send_good(8'hA5);
    chk("a5_led", 32'(LED_Out), 32'(exp_led));
    drain("a5");

    nf = mon_frames;
    RX_Pin_In = 1'b0;
    repeat (CPB / 2 - 3) @(negedge clk);
    RX_Pin_In = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    chk("glitch_led", 32'(LED_Out), 32'(exp_led));
    chk("glitch_frames", 32'(mon_frames), 32'(nf));
    chk("glitch_tx", 32'(TX_Pin_Out), 32'd1);

    send_bits(8'h3C, 1'b0);
    repeat (12 * CPB) @(negedge clk);
    chk("ferr_led", 32'(LED_Out), 32'(exp_led));
    chk("ferr_frames", 32'(mon_frames), 32'(nf));
    send_good(8'h5A);
    chk("5a_led", 32'(LED_Out), 32'(exp_led));
    drain("5a");

    send_good(8'h3C);
    send_good(8'hC3);
    for (int i = 0; i < 4; i++) send_good(8'($urandom));
    chk("b2b_led", 32'(LED_Out), 32'(exp_led));
    drain("b2b");
    repeat (3 * CPB) @(negedge clk);

    b = 8'($urandom) | 8'h10;
    RX_Pin_In = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX_Pin_In = b[i];
      repeat (CPB) @(negedge clk);
    end
    RX_Pin_In = b[4];
    repeat (CPB / 2) @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);
    exp_led = 8'h00;
    chk("rxrst_tx", 32'(TX_Pin_Out), 32'd1);
    chk("rxrst_led", 32'(LED_Out), 32'(exp_led));
    RSTn = 1'b0;
    RX_Pin_In = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("rxrst_hold", 32'(LED_Out), 32'(exp_led));
    send_good(8'h81);
    chk("81_led", 32'(LED_Out), 32'(exp_led));
    drain("81");
    repeat (3 * CPB) @(negedge clk);

    b = 8'($urandom);
    send_bits(b, 1'b1);
    chk("txrst_pre_led", 32'(LED_Out), 32'(b));
    repeat (3 * CPB) @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);
    chk("txrst_tx", 32'(TX_Pin_Out), 32'd1);
    chk("txrst_led", 32'(LED_Out), 32'h00);
    RSTn = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    chk("txrst_abort", 32'(mon_aborts), 32'd1);
    chk("txrst_nobyte", 32'(mon_bytes.size()), 32'd0);
    chk("txrst_idle", 32'(TX_Pin_Out), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
